// File: rtl/flag_stack_unit.sv
// flag_stack_unit: registered condition-flag register for the PIM controller.
// It captures datapath status under per-flag write masks and keeps a LIFO of
// flag snapshots, so that nested CALL/RETURN sequences restore the caller's flags.
//
// Flag vector order (LSB -> MSB): {Col, Ziw[0..NUM_IW-1], Zimm, Co, Call, Sign}
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   upd_en, upd_mask    masked flag update request (1 = bit loads new value)
//   col_pim, iw, imm_in,
//   co_pim, call_mux,
//   sign_pim            new flag sources (Ziw[i] = field i of iw is nonzero)
//   push, pop           save current flags / restore flags from LIFO top
//   err_clr             clear sticky ovf_err / unf_err
//   flags               registered flag vector
//   stack_cnt           number of valid LIFO entries
//   stack_full/empty    decodes of stack_cnt
//   ovf_err / unf_err   sticky: push while full / pop while empty

// Per-field nonzero detect; one instance per instruction-word field.
module flag_stack_zdet #(
  parameter int W = 6
) (
  input  logic [W-1:0] fld,
  output logic         nz
);
  assign nz = |fld;
endmodule

module flag_stack_unit #(
  parameter int IW_W        = 6,
  parameter int NUM_IW      = 2,
  parameter int STACK_DEPTH = 4,
  localparam int NF = NUM_IW + 5,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_en,
  input  logic [NF-1:0]          upd_mask,
  input  logic                   col_pim,
  input  logic [NUM_IW*IW_W-1:0] iw,
  input  logic                   imm_in,
  input  logic                   co_pim,
  input  logic                   call_mux,
  input  logic                   sign_pim,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   err_clr,
  output logic [NF-1:0]          flags,
  output logic [CW-1:0]          stack_cnt,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   ovf_err,
  output logic                   unf_err
);

  logic [NUM_IW-1:0]               ziw;
  logic [NF-1:0]                   new_flags;
  logic [STACK_DEPTH-1:0][NF-1:0]  stk;
  logic [NF-1:0]                   top;
  logic                            do_push, do_pop, ovf_set, unf_set;

  for (genvar g = 0; g < NUM_IW; g++) begin : g_zdet
    flag_stack_zdet #(.W(IW_W)) u_zdet (
      .fld (iw[g*IW_W +: IW_W]),
      .nz  (ziw[g])
    );
  end

  assign new_flags = {sign_pim, call_mux, co_pim, imm_in, ziw, col_pim};

  assign stack_full  = (stack_cnt == CW'(STACK_DEPTH));
  assign stack_empty = (stack_cnt == '0);

  // Simultaneous push and pop cancel: stack untouched, no error raised.
  assign do_push = push & ~pop & ~stack_full;
  assign do_pop  = pop & ~push & ~stack_empty;
  assign ovf_set = push & ~pop & stack_full;
  assign unf_set = pop & ~push & stack_empty;

  // Top-of-stack read; decoding each slot avoids indexing with a count that
  // can exceed the entry range.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (stack_cnt == CW'(i + 1)) top = stk[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags     <= '0;
      stack_cnt <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      stk       <= '0;
    end else begin
      // A restore takes the saved value verbatim; the update is discarded.
      if (do_pop)
        flags <= top;
      else if (upd_en)
        flags <= (flags & ~upd_mask) | (new_flags & upd_mask);

      // Snapshot is the pre-update value held before this edge.
      for (int i = 0; i < STACK_DEPTH; i++)
        if (do_push && stack_cnt == CW'(i)) stk[i] <= flags;

      if (do_push)
        stack_cnt <= stack_cnt + CW'(1);
      else if (do_pop)
        stack_cnt <= stack_cnt - CW'(1);

      // A same-cycle error event beats the clear.
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_flag_stack_unit.sv
// Directed bench for flag_stack_unit (default parameters: NF=7, CW=3, depth 4).
module tb_flag_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_en;
  logic [6:0]  upd_mask;
  logic        col_pim;
  logic [11:0] iw;
  logic        imm_in, co_pim, call_mux, sign_pim;
  logic        push, pop, err_clr;
  logic [6:0]  flags;
  logic [2:0]  stack_cnt;
  logic        stack_full, stack_empty, ovf_err, unf_err;

  int n_cmp = 0;
  int n_bad = 0;

  flag_stack_unit dut (
    .clk(clk), .rst_n(rst_n), .upd_en(upd_en), .upd_mask(upd_mask),
    .col_pim(col_pim), .iw(iw), .imm_in(imm_in), .co_pim(co_pim),
    .call_mux(call_mux), .sign_pim(sign_pim), .push(push), .pop(pop),
    .err_clr(err_clr), .flags(flags), .stack_cnt(stack_cnt),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    upd_en = 0; upd_mask = '0; col_pim = 0; iw = '0; imm_in = 0;
    co_pim = 0; call_mux = 0; sign_pim = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  // Drive sources so that an all-ones masked update yields flag vector v.
  task automatic set_src(input logic [6:0] v, input logic [6:0] m);
    upd_en = 1; upd_mask = m;
    col_pim = v[0];
    iw = {5'd0, v[2], 5'd0, v[1]};
    imm_in = v[3]; co_pim = v[4]; call_mux = v[5]; sign_pim = v[6];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_stat(input string tag, input logic [6:0] f, input logic [2:0] c,
                          input logic o, input logic u);
    chk({tag, ".flags"}, flags, f);
    chk({tag, ".cnt"}, stack_cnt, c);
    chk({tag, ".full"}, stack_full, c == 3'd4);
    chk({tag, ".empty"}, stack_empty, c == 3'd0);
    chk({tag, ".ovf"}, ovf_err, o);
    chk({tag, ".unf"}, unf_err, u);
  endtask

  logic [6:0] vals [4];

  initial begin
    vals[0] = 7'h11; vals[1] = 7'h22; vals[2] = 7'h33; vals[3] = 7'h44;
    rst_n = 0;
    idle();
    #12;
    chk_stat("reset", 7'h00, 3'd0, 0, 0);
    rst_n = 1;
    #2;

    // Field0 = 5 (nonzero), field1 = 0; Co and Sign set.
    upd_en = 1; upd_mask = 7'h7F; iw = {6'd0, 6'd5}; co_pim = 1; sign_pim = 1;
    tick();
    chk("upd_all", flags, 7'h52);

    // Mask selects only Co.
    set_src(7'h00, 7'h7F); tick();
    chk("clear", flags, 7'h00);
    upd_en = 1; upd_mask = 7'h10; co_pim = 1; col_pim = 1; tick();
    chk("mask_co", flags, 7'h10);
    set_src(7'h6F, 7'h7F); upd_en = 0; tick();
    chk("upd_off", flags, 7'h10);

    // Two pushes; second push carries an update, snapshot is pre-update.
    set_src(7'h55, 7'h7F); tick();
    push = 1; tick();
    chk("push1.cnt", stack_cnt, 3'd1);
    set_src(7'h2A, 7'h7F); tick();
    set_src(7'h0F, 7'h7F); push = 1; tick();
    chk_stat("push2", 7'h0F, 3'd2, 0, 0);
    pop = 1; tick();
    chk_stat("pop1", 7'h2A, 3'd1, 0, 0);
    pop = 1; tick();
    chk_stat("pop2", 7'h55, 3'd0, 0, 0);

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < 4; i++) begin
      set_src(vals[i], 7'h7F); tick();
      push = 1; tick();
    end
    chk_stat("fill", 7'h44, 3'd4, 0, 0);
    set_src(7'h7F, 7'h7F); push = 1; tick();
    chk_stat("ovf", 7'h7F, 3'd4, 1, 0);
    for (int i = 3; i >= 0; i--) begin
      pop = 1; tick();
      chk($sformatf("drain%0d", i), flags, vals[i]);
    end
    chk_stat("drained", 7'h11, 3'd0, 1, 0);
    pop = 1; tick();
    chk_stat("unf", 7'h11, 3'd0, 1, 1);
    err_clr = 1; tick();
    chk_stat("clr", 7'h11, 3'd0, 0, 0);
    // Clear coinciding with an underflow: underflow wins.
    err_clr = 1; pop = 1; tick();
    chk_stat("clr_vs_unf", 7'h11, 3'd0, 0, 1);
    err_clr = 1; tick();

    // Push+pop together: stack untouched, update applies.
    push = 1; tick();
    push = 1; pop = 1; upd_en = 1; upd_mask = 7'h40; sign_pim = 1; tick();
    chk_stat("pushpop", 7'h51, 3'd1, 0, 0);
    // Pop ignores the same-cycle update.
    set_src(7'h7F, 7'h7F); pop = 1; tick();
    chk_stat("pop_upd", 7'h11, 3'd0, 0, 0);

    // Async reset between edges.
    set_src(7'h33, 7'h7F); tick();
    push = 1; tick();
    push = 1; tick();
    set_src(7'h7F, 7'h7F); push = 1; tick(); // ovf not yet: cnt 2 -> 3
    chk("pre_rst.cnt", stack_cnt, 3'd3);
    #2;
    rst_n = 0;
    #2;
    chk_stat("async_rst", 7'h00, 3'd0, 0, 0);
    #1;
    rst_n = 1;
    pop = 1; tick();
    chk_stat("rst_pop", 7'h00, 3'd0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
